// File: rtl/imem_boot_arbiter.sv
// rtl/imem_boot_arbiter.sv - instruction memory port arbiter between SOC boot loader and CPU fetch
// Holds the CPU in reset while an image is streamed in, then releases it after a settle delay.
module imem_boot_arbiter #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_ADDR_BITS  = 12,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     LD_START,
    input  logic [RAM_ADDR_BITS-2:0] LD_LEN,
    input  logic                     LD_VALID,
    input  logic [RAM_WIDTH-1:0]     LD_DATA,
    output logic                     LD_READY,
    input  logic                     LD_ABORT,
    input  logic [RAM_ADDR_BITS-1:0] FETCH_ADDR,
    output logic [RAM_WIDTH-1:0]     FETCH_INSTR,
    input  logic [RAM_WIDTH-1:0]     MEM_RD,
    output logic [RAM_ADDR_BITS-1:0] MEM_A,
    output logic [RAM_WIDTH-1:0]     MEM_WDATA,
    output logic                     MEM_WE,
    output logic                     CPU_RST,
    output logic                     LOAD_DONE,
    output logic                     LOAD_ERR,
    output logic [RAM_ADDR_BITS-2:0] WORD_CNT
);

    localparam int LW = RAM_ADDR_BITS - 1;
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    // Largest image the CPU can actually fetch: reads index by byte address >> 2.
    localparam logic [LW-1:0] MAXW = LW'(2 ** (RAM_ADDR_BITS - 2));

    localparam logic [1:0] S_HOLD   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rel_q, rel_d;
    logic          ready_q, ready_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic len_ok;
    logic accept;
    logic last_word;

    assign len_ok    = (LD_LEN != '0) && (LD_LEN <= MAXW);
    assign accept    = (state_q == S_LOAD) && ready_q && LD_VALID && !LD_ABORT;
    assign last_word = (cnt_q == len_q - LW'(1));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rel_d     = rel_q;
        ready_d   = ready_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            S_HOLD: begin
                cpu_rst_d = 1'b1;
                ready_d   = 1'b0;
                if (LD_START) begin
                    if (!len_ok) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        len_d   = LD_LEN;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (LD_ABORT) begin
                    err_d   = 1'b1;
                    ready_d = 1'b0;
                    state_d = S_HOLD;
                end else if (accept) begin
                    cnt_d = cnt_q + LW'(1);
                    if (last_word) begin
                        ready_d = 1'b0;
                        rel_d   = RW'(RELEASE_CYCLES);
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (LD_ABORT) begin
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    rel_d = rel_q - RW'(1);
                    if (rel_q == RW'(1)) begin
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_RUN;
                    end
                end
            end
            default: begin
                cpu_rst_d = 1'b0;
                // An invalid reload request must not disturb a running CPU.
                if (LD_START) begin
                    if (!len_ok) begin
                        err_d = 1'b1;
                    end else begin
                        err_d     = 1'b0;
                        len_d     = LD_LEN;
                        cnt_d     = '0;
                        ready_d   = 1'b1;
                        cpu_rst_d = 1'b1;
                        state_d   = S_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_HOLD;
            len_q     <= '0;
            cnt_q     <= '0;
            rel_q     <= '0;
            ready_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rel_q     <= rel_d;
            ready_q   <= ready_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign LD_READY    = ready_q;
    assign CPU_RST     = cpu_rst_q;
    assign LOAD_DONE   = done_q;
    assign LOAD_ERR    = err_q;
    assign WORD_CNT    = cnt_q;
    assign MEM_WE      = accept;
    assign MEM_WDATA   = LD_DATA;
    assign MEM_A       = (state_q == S_RUN) ? FETCH_ADDR : {1'b0, cnt_q};
    assign FETCH_INSTR = (state_q == S_RUN) ? MEM_RD : '0;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// tb/tb_imem_boot_arbiter.sv - directed self-checking bench for imem_boot_arbiter
module tb_imem_boot_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LD_START;
    logic [10:0] LD_LEN;
    logic        LD_VALID;
    logic [31:0] LD_DATA;
    logic        LD_READY;
    logic        LD_ABORT;
    logic [11:0] FETCH_ADDR;
    logic [31:0] FETCH_INSTR;
    logic [31:0] MEM_RD;
    logic [11:0] MEM_A;
    logic [31:0] MEM_WDATA;
    logic        MEM_WE;
    logic        CPU_RST;
    logic        LOAD_DONE;
    logic        LOAD_ERR;
    logic [10:0] WORD_CNT;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int d0;
    int n;
    int exp_a;
    logic [11:0] wr_addr[$];
    logic [31:0] mem [0:4095];
    logic [31:0] data3 [0:2];
    logic        gap_v [0:3];

    imem_boot_arbiter #(.RAM_WIDTH(32), .RAM_ADDR_BITS(12), .RELEASE_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .LD_START(LD_START), .LD_LEN(LD_LEN), .LD_VALID(LD_VALID),
        .LD_DATA(LD_DATA), .LD_READY(LD_READY), .LD_ABORT(LD_ABORT), .FETCH_ADDR(FETCH_ADDR),
        .FETCH_INSTR(FETCH_INSTR), .MEM_RD(MEM_RD), .MEM_A(MEM_A), .MEM_WDATA(MEM_WDATA),
        .MEM_WE(MEM_WE), .CPU_RST(CPU_RST), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR),
        .WORD_CNT(WORD_CNT)
    );

    always #5 CLK = ~CLK;

    // Memory model: word-indexed writes, byte-addressed combinational reads.
    always @(posedge CLK) if (MEM_WE) mem[MEM_A] <= MEM_WDATA;
    assign MEM_RD = mem[MEM_A >> 2];

    always @(negedge CLK) begin
        if (MEM_WE) wr_addr.push_back(MEM_A);
        if (LOAD_DONE) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        data3[0] = 32'h11111111; data3[1] = 32'h22222222; data3[2] = 32'h33333333;
        gap_v[0] = 1'b1; gap_v[1] = 1'b0; gap_v[2] = 1'b0; gap_v[3] = 1'b1;
        RST = 1'b1; LD_START = 0; LD_LEN = 0; LD_VALID = 0; LD_DATA = 0; LD_ABORT = 0; FETCH_ADDR = 0;
        repeat (2) @(posedge CLK);
        #3;
        chk("rst_cpu_rst", CPU_RST, 1);
        chk("rst_ready", LD_READY, 0);
        chk("rst_done", LOAD_DONE, 0);
        chk("rst_err", LOAD_ERR, 0);
        chk("rst_wcnt", WORD_CNT, 0);
        chk("rst_instr", FETCH_INSTR, 0);
        chk("rst_we", MEM_WE, 0);
        tick();
        RST = 1'b0;
        tick();

        // Three words back-to-back, then settle timing.
        LD_START = 1; LD_LEN = 3;
        tick();
        LD_START = 0;
        for (int i = 0; i < 3; i++) begin
            LD_VALID = 1; LD_DATA = data3[i];
            #2;
            chk("ld3_we", MEM_WE, 1);
            chk("ld3_addr", MEM_A, i);
            chk("ld3_ready", LD_READY, 1);
            tick();
        end
        LD_VALID = 0;
        for (int k = 1; k <= 5; k++) begin
            #2;
            chk("ld3_cpu_rst", CPU_RST, (k < 5) ? 1 : 0);
            chk("ld3_done", LOAD_DONE, (k == 5) ? 1 : 0);
            chk("ld3_settle_we", MEM_WE, 0);
            tick();
        end
        #2;
        chk("ld3_done_once", done_cnt, 1);
        chk("ld3_done_low", LOAD_DONE, 0);
        chk("ld3_wcnt", WORD_CNT, 3);
        chk("ld3_nwr", wr_addr.size(), 3);
        for (int i = 0; i < 3; i++) chk("ld3_wr_addr", wr_addr[i], i);
        wr_addr.delete();

        // Fetch in RUN: zero-latency read through the arbiter.
        FETCH_ADDR = 12'h008;
        #1;
        chk("fetch8", FETCH_INSTR, 32'h33333333);
        chk("fetch8_a", MEM_A, 12'h008);
        chk("fetch8_we", MEM_WE, 0);
        FETCH_ADDR = 12'h004;
        #1;
        chk("fetch4", FETCH_INSTR, 32'h22222222);
        tick();

        // Reload from RUN with one word.
        LD_START = 1; LD_LEN = 1;
        #2;
        chk("reload_pre_rst", CPU_RST, 0);
        tick();
        LD_START = 0; LD_VALID = 1; LD_DATA = 32'hAAAA5555;
        #2;
        chk("reload_rst", CPU_RST, 1);
        chk("reload_ready", LD_READY, 1);
        chk("reload_we", MEM_WE, 1);
        chk("reload_addr", MEM_A, 0);
        tick();
        LD_VALID = 0;
        n = 1;
        #2;
        while (CPU_RST === 1'b1 && n < 20) begin
            tick();
            #2;
            n++;
        end
        chk("reload_release_lat", n, 5);
        chk("reload_done", LOAD_DONE, 1);
        FETCH_ADDR = 12'h000;
        #1;
        chk("reload_fetch", FETCH_INSTR, 32'hAAAA5555);
        chk("reload_nwr", wr_addr.size(), 1);
        tick();
        wr_addr.delete();

        // Invalid reload in RUN leaves CPU running.
        LD_START = 1; LD_LEN = 0;
        tick();
        LD_START = 0;
        #2;
        chk("run_bad_err", LOAD_ERR, 1);
        chk("run_bad_cpu", CPU_RST, 0);
        chk("run_bad_fetch", FETCH_INSTR, 32'hAAAA5555);
        tick();

        // Gapped load of 2, then async reset mid-SETTLE.
        LD_START = 1; LD_LEN = 2;
        tick();
        LD_START = 0;
        exp_a = 0;
        for (int i = 0; i < 4; i++) begin
            LD_VALID = gap_v[i]; LD_DATA = 32'hC0DE0000 + i;
            #2;
            chk("gap_err", LOAD_ERR, 0);
            chk("gap_we", MEM_WE, gap_v[i]);
            if (gap_v[i]) begin
                chk("gap_addr", MEM_A, exp_a);
                exp_a++;
            end
            tick();
        end
        LD_VALID = 0;
        chk("gap_nwr", wr_addr.size(), 2);
        chk("gap_wr1", wr_addr[1], 1);
        d0 = done_cnt;
        tick();
        #1;
        RST = 1;
        #1;
        chk("arst_cpu", CPU_RST, 1);
        chk("arst_ready", LD_READY, 0);
        chk("arst_wcnt", WORD_CNT, 0);
        chk("arst_instr", FETCH_INSTR, 0);
        tick();
        RST = 0;
        repeat (8) tick();
        chk("arst_no_done", done_cnt, d0);
        chk("arst_hold_cpu", CPU_RST, 1);
        wr_addr.delete();

        // Bad lengths in HOLD, then a valid start clears the error.
        LD_START = 1; LD_LEN = 0; LD_VALID = 1;
        #2;
        chk("len0_we", MEM_WE, 0);
        tick();
        #2;
        chk("len0_err", LOAD_ERR, 1);
        chk("len0_ready", LD_READY, 0);
        LD_LEN = 11'd1025;
        tick();
        #2;
        chk("lenmax_err", LOAD_ERR, 1);
        chk("lenmax_ready", LD_READY, 0);
        chk("lenmax_cpu", CPU_RST, 1);
        LD_LEN = 4; LD_VALID = 0;
        tick();
        LD_START = 0;
        #2;
        chk("good_err_clr", LOAD_ERR, 0);
        chk("good_ready", LD_READY, 1);
        chk("bad_nwr", wr_addr.size(), 0);
        tick();

        // Abort together with the third word of four.
        for (int i = 0; i < 3; i++) begin
            LD_VALID = 1; LD_DATA = 32'hBEEF0000 + i; LD_ABORT = (i == 2);
            #2;
            chk("abort_we", MEM_WE, (i != 2) ? 1 : 0);
            tick();
        end
        LD_VALID = 0; LD_ABORT = 0;
        d0 = done_cnt;
        #2;
        chk("abort_err", LOAD_ERR, 1);
        chk("abort_wcnt", WORD_CNT, 2);
        chk("abort_cpu", CPU_RST, 1);
        chk("abort_ready", LD_READY, 0);
        chk("abort_nwr", wr_addr.size(), 2);
        repeat (8) tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_hold_cpu", CPU_RST, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
